vga_timing_gen: RTL

- Parametrised VGA raster timing generator with pixel-fetch lookahead and a registered colour/sync output stage.
- Successor to the fixed 640x480 generator:
  - timing, sync polarity and colour width are parameters;
  - pixel coordinates are issued FETCH_LEAD cycles ahead, so a pipelined framebuffer/BRAM can return data in time;
  - provides a pixel-clock enable, frame/line strobes and a frame counter.
- Sits between the framebuffer read port and the VGA/DVI pins.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, total-length helper and the bundle types for the VGA
// raster generator.
package vga_pkg;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_FETCH_LEAD = 2;
    localparam int DEF_COLOR_W    = 3;
    localparam int DEF_BORDER     = 10;

    function automatic int vga_total(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = vga_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = vga_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    // Per-position decode that travels alongside the pixel fetch latency.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic lower_blank;
        logic border;
        logic line_start;
        logic frame_start;
    } timing_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; every stage reloads RESET_VAL on reset so the
// pipeline drains idle values rather than stale decode.
module vga_delay_line #(
    parameter int               WIDTH     = 7,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else if (enable) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: lookahead fetch counters, decode delayed to
// match framebuffer latency, and a registered colour/sync stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int FETCH_LEAD = DEF_FETCH_LEAD,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int BORDER     = DEF_BORDER
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   border_en,
    input  logic [3*COLOR_W-1:0]   pix_in,
    output logic [10:0]            fetch_x,
    output logic [9:0]             fetch_y,
    output logic                   fetch_valid,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank,
    output logic                   lower_blank,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [15:0]            frame_count
);

    localparam int H_TOTAL  = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    if (FETCH_LEAD < 1) begin : g_bad_lead
        $error("vga_timing_gen: FETCH_LEAD must be at least 1");
    end
    if (2 * BORDER > H_VISIBLE) begin : g_bad_border
        $error("vga_timing_gen: border wider than half the visible line");
    end
    if (HW > 11 || VW > 10) begin : g_bad_width
        $error("vga_timing_gen: totals do not fit the 11/10-bit fetch ports");
    end

    localparam timing_t TIMING_IDLE = '{
        hsync:       !H_SYNC_POL,
        vsync:       !V_SYNC_POL,
        blank:       1'b1,
        lower_blank: 1'b0,
        border:      1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    timing_t       dec;
    timing_t       dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (enable) begin
            if (h == HW'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    always_comb begin
        dec             = TIMING_IDLE;
        dec.hsync       = (h >= HW'(HS_FIRST) && h <= HW'(HS_LAST)) ? H_SYNC_POL : !H_SYNC_POL;
        dec.vsync       = (v >= VW'(VS_FIRST) && v <= VW'(VS_LAST)) ? V_SYNC_POL : !V_SYNC_POL;
        dec.blank       = (h >= HW'(H_VISIBLE)) || (v >= VW'(V_VISIBLE));
        dec.lower_blank = (v >= VW'(V_VISIBLE));
        // Only meaningful inside the visible area; blank masks the rest.
        dec.border      = (h < HW'(BORDER)) || (h >= HW'(H_VISIBLE - BORDER)) ||
                          (v < VW'(BORDER)) || (v >= VW'(V_VISIBLE - BORDER));
        dec.line_start  = (h == '0);
        dec.frame_start = (h == '0) && (v == '0);
    end

    assign fetch_x     = 11'(h);
    assign fetch_y     = 10'(v);
    assign fetch_valid = !reset && !dec.blank;

    if (FETCH_LEAD > 1) begin : g_dly
        vga_delay_line #(
            .WIDTH     ($bits(timing_t)),
            .DEPTH     (FETCH_LEAD - 1),
            .RESET_VAL (TIMING_IDLE)
        ) u_delay (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .din    (dec),
            .dout   (dly)
        );
    end else begin : g_no_dly
        assign dly = dec;
    end

    logic [COLOR_W-1:0] red_d, green_d, blue_d;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (!dly.blank) begin
            if (border_en && dly.border) {red_d, green_d, blue_d} = '1;
            else                         {red_d, green_d, blue_d} = pix_in;
        end
    end

    // The first frame after reset is not a completed frame, so it only arms the counter.
    logic seen_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= TIMING_IDLE.hsync;
            vsync       <= TIMING_IDLE.vsync;
            blank       <= 1'b1;
            lower_blank <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            seen_frame  <= 1'b0;
        end else if (enable) begin
            red         <= red_d;
            green       <= green_d;
            blue        <= blue_d;
            hsync       <= dly.hsync;
            vsync       <= dly.vsync;
            blank       <= dly.blank;
            lower_blank <= dly.lower_blank;
            line_start  <= dly.line_start;
            frame_start <= dly.frame_start;
            if (dly.frame_start) begin
                if (seen_frame) frame_count <= frame_count + 16'd1;
                else            seen_frame  <= 1'b1;
            end
        end
    end

endmodule
